// File: rtl/bomber_pkg.sv
// bomber_pkg: shared FSM states, tile geometry and the pillar-tile predicate
package bomber_pkg;
    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;
    localparam int TILE   = 32;
    localparam int ORIGIN = 32;
    function automatic logic odd_tile(input logic [9:0] c);
        logic [9:0] t;
        t = (c - 10'(ORIGIN)) >> $clog2(TILE);
        return (c >= 10'(ORIGIN)) && t[0];
    endfunction
endpackage

// File: rtl/tile_collide.sv
// tile_collide: true when all four box corners are inside the arena and none sits in a pillar
module tile_collide
    import bomber_pkg::*;
#(
    parameter int X_MIN = 32,
    parameter int X_MAX = 575,
    parameter int Y_MIN = 32,
    parameter int Y_MAX = 447
)(
    input  logic [9:0] left,
    input  logic [9:0] right,
    input  logic [9:0] top,
    input  logic [9:0] bottom,
    output logic       ok
);
    logic in_bounds;
    logic in_pillar;
    assign in_bounds = left >= 10'(X_MIN) && right <= 10'(X_MAX) &&
                       top >= 10'(Y_MIN) && bottom <= 10'(Y_MAX);
    assign in_pillar = (odd_tile(left)  && odd_tile(top))    ||
                       (odd_tile(right) && odd_tile(top))    ||
                       (odd_tile(left)  && odd_tile(bottom)) ||
                       (odd_tile(right) && odd_tile(bottom));
    assign ok = in_bounds && !in_pillar;
endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: per-frame player movement, blast damage/lives FSM and bomb drop with cooldown
module player_ctrl
    import bomber_pkg::*;
#(
    parameter logic [7:0] KEY_UP        = 8'h1A,
    parameter logic [7:0] KEY_DOWN      = 8'h16,
    parameter logic [7:0] KEY_LEFT      = 8'h04,
    parameter logic [7:0] KEY_RIGHT     = 8'h07,
    parameter logic [7:0] KEY_BOMB      = 8'h19,
    parameter int         START_X       = 34,
    parameter int         START_Y       = 34,
    parameter int         X_SIZE        = 18,
    parameter int         Y_SIZE        = 26,
    parameter int         STEP          = 1,
    parameter int         X_MIN         = 32,
    parameter int         X_MAX         = 575,
    parameter int         Y_MIN         = 32,
    parameter int         Y_MAX         = 447,
    parameter int         LIVES         = 3,
    parameter int         INVULN_FRAMES = 120,
    parameter int         BOMB_COOLDOWN = 60
)(
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic [9:0] blastX,
    input  logic [9:0] blastY,
    input  logic [9:0] blastXS,
    input  logic [9:0] blastYS,
    input  logic       blast_on,
    output logic [9:0] userX,
    output logic [9:0] userY,
    output logic       bomb_drop,
    output logic [9:0] bombX,
    output logic [9:0] bombY,
    output logic [2:0] heart,
    output logic       damage,
    output logic       dead,
    output logic       invuln
);
    state_t     state, state_nx;
    logic [9:0] inv_cnt, cool_cnt;
    logic [9:0] cand_x, cand_y, mid_x, mid_y;
    logic       key_prev, bomb_key, no_wrap, fits, hit, drop;
    logic       mv_left, mv_right, mv_up, mv_down;
    logic [10:0] px_end, py_end, bx_end, by_end;

    assign mv_left  = keycode == KEY_LEFT;
    assign mv_right = keycode == KEY_RIGHT;
    assign mv_up    = keycode == KEY_UP;
    assign mv_down  = keycode == KEY_DOWN;
    assign bomb_key = keycode == KEY_BOMB;

    // reject a step toward zero before the subtraction could wrap
    assign no_wrap = !(mv_left && userX < 10'(STEP)) && !(mv_up && userY < 10'(STEP));
    assign cand_x  = mv_left ? userX - 10'(STEP) : mv_right ? userX + 10'(STEP) : userX;
    assign cand_y  = mv_up   ? userY - 10'(STEP) : mv_down  ? userY + 10'(STEP) : userY;

    tile_collide #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
    ) u_collide (
        .left(cand_x),
        .right(cand_x + 10'(X_SIZE)),
        .top(cand_y),
        .bottom(cand_y + 10'(Y_SIZE)),
        .ok(fits)
    );

    // 11-bit edges so a blast reaching the top of the 10-bit range cannot wrap
    assign px_end = {1'b0, userX} + 11'(X_SIZE);
    assign py_end = {1'b0, userY} + 11'(Y_SIZE);
    assign bx_end = {1'b0, blastX} + {1'b0, blastXS};
    assign by_end = {1'b0, blastY} + {1'b0, blastYS};
    assign hit = blast_on && state == ALIVE &&
                 {1'b0, userX} < bx_end && {1'b0, blastX} < px_end &&
                 {1'b0, userY} < by_end && {1'b0, blastY} < py_end;

    assign drop  = bomb_key && !key_prev && state != DEAD && cool_cnt == 10'd0 && !hit;
    assign mid_x = userX + 10'(X_SIZE / 2);
    assign mid_y = userY + 10'(Y_SIZE / 2);

    assign dead   = state == DEAD;
    assign invuln = state == INVULN;

    always_comb begin
        state_nx = state;
        state_nx = hit ? (heart == 3'd1 ? DEAD : INVULN)
                 : (state == INVULN && inv_cnt <= 10'd1) ? ALIVE : state;
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ALIVE;
            userX     <= 10'(START_X);
            userY     <= 10'(START_Y);
            heart     <= 3'(LIVES);
            inv_cnt   <= '0;
            cool_cnt  <= '0;
            key_prev  <= 1'b0;
            damage    <= 1'b0;
            bomb_drop <= 1'b0;
            bombX     <= '0;
            bombY     <= '0;
        end else begin
            state     <= state_nx;
            key_prev  <= bomb_key;
            damage    <= hit;
            bomb_drop <= drop;
            inv_cnt   <= hit  ? 10'(INVULN_FRAMES) : inv_cnt  - {9'd0, inv_cnt  != 10'd0};
            cool_cnt  <= drop ? 10'(BOMB_COOLDOWN) : cool_cnt - {9'd0, cool_cnt != 10'd0};
            if (hit) begin
                heart <= heart - 3'd1;
                userX <= 10'(START_X);
                userY <= 10'(START_Y);
            end else if (state != DEAD && no_wrap && fits) begin
                userX <= cand_x;
                userY <= cand_y;
            end
            if (drop) begin
                bombX <= mid_x & ~10'(TILE - 1);
                bombY <= mid_y & ~10'(TILE - 1);
            end
        end
    end
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: movement vector table with scoreboard plus hit, death, bomb and reset sequences
module tb_player_ctrl;
    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic [9:0] blastX, blastY, blastXS, blastYS;
    logic       blast_on;
    logic [9:0] userX, userY, bombX, bombY;
    logic       bomb_drop, damage, dead, invuln;
    logic [2:0] heart;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] key;
        int         frames;
        int         ex;
        int         ey;
        int         eh;
    } vec_t;

    vec_t tbl[10];
    vec_t exp_q[$];

    player_ctrl dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
        .blastX(blastX), .blastY(blastY), .blastXS(blastXS), .blastYS(blastYS),
        .blast_on(blast_on), .userX(userX), .userY(userY),
        .bomb_drop(bomb_drop), .bombX(bombX), .bombY(bombY),
        .heart(heart), .damage(damage), .dead(dead), .invuln(invuln)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic do_hit();
        blast_on = 1'b1;
        @(negedge frame_clk);
        blast_on = 1'b0;
    endtask

    initial begin
        int pulses, early, late, dmg, inv;
        vec_t e;
        tbl[0] = '{8'h07, 10, 44, 34, 3};
        tbl[1] = '{8'h00,  3, 44, 34, 3};
        tbl[2] = '{8'h04, 10, 34, 34, 3};
        tbl[3] = '{8'h1A,  5, 34, 32, 3};
        tbl[4] = '{8'h16, 42, 34, 74, 3};
        tbl[5] = '{8'h04,  5, 32, 74, 3};
        tbl[6] = '{8'h07, 20, 45, 74, 3};
        tbl[7] = '{8'h1A, 40, 45, 34, 3};
        tbl[8] = '{8'h05,  2, 45, 34, 3};
        tbl[9] = '{8'h04,  1, 44, 34, 3};

        Reset_n = 1'b0; keycode = 8'h00; blast_on = 1'b0;
        blastX = 10'd32; blastY = 10'd32; blastXS = 10'd100; blastYS = 10'd100;
        #12;
        chk("rst_x", userX, 34);
        chk("rst_y", userY, 34);
        chk("rst_heart", heart, 3);
        chk("rst_flags", {bomb_drop, damage, dead, invuln}, 0);
        @(negedge frame_clk);
        Reset_n = 1'b1;

        foreach (tbl[i]) begin
            keycode = tbl[i].key;
            frames(tbl[i].frames);
            exp_q.push_back(tbl[i]);
            e = exp_q.pop_front();
            chk($sformatf("mv%0d_x", i), userX, e.ex);
            chk($sformatf("mv%0d_y", i), userY, e.ey);
            chk($sformatf("mv%0d_heart", i), heart, e.eh);
            chk($sformatf("mv%0d_flags", i), {dead, invuln, damage}, 0);
        end

        // bomb held for 100 frames yields a single pulse
        keycode = 8'h19; pulses = 0;
        for (int f = 0; f < 100; f++) begin
            @(negedge frame_clk);
            pulses += int'(bomb_drop);
        end
        chk("hold_pulses", pulses, 1);
        chk("bomb_x", bombX, 32);
        chk("bomb_y", bombY, 32);
        chk("bomb_nomove", userX, 44);
        keycode = 8'h00;
        frames(5);
        keycode = 8'h19;
        @(negedge frame_clk);
        chk("press_drop", bomb_drop, 1);
        early = 0; late = 0;
        for (int f = 1; f <= 80; f++) begin
            keycode = (f == 30 || f == 31 || f == 70) ? 8'h19 : 8'h00;
            @(negedge frame_clk);
            if (bomb_drop) begin
                if (f == 70) late++;
                else early++;
            end
        end
        chk("cooldown_block", early, 0);
        chk("cooldown_expired", late, 1);
        keycode = 8'h00;

        // first hit, then a second blast inside the immunity window
        do_hit();
        chk("hit_damage", damage, 1);
        chk("hit_heart", heart, 2);
        chk("hit_pos", {22'd0, userX, userY}, {22'd0, 10'd34, 10'd34});
        chk("hit_invuln", invuln, 1);
        dmg = 0; inv = 0;
        for (int k = 1; k <= 130; k++) begin
            blast_on = (k >= 3 && k <= 7);
            @(negedge frame_clk);
            dmg += int'(damage);
            inv += int'(invuln);
        end
        blast_on = 1'b0;
        chk("invuln_frames", inv + 1, 120);
        chk("invuln_no_damage", dmg, 0);
        chk("invuln_heart", heart, 2);

        // reset mid-INVULN after moving
        do_hit();
        chk("hit2_heart", heart, 1);
        keycode = 8'h07;
        frames(5);
        keycode = 8'h00;
        chk("invuln_moves", userX, 39);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_x", userX, 34);
        chk("arst_heart", heart, 3);
        chk("arst_flags", {bomb_drop, damage, dead, invuln}, 0);
        chk("arst_bomb", {bombX, bombY}, 0);
        @(negedge frame_clk);
        Reset_n = 1'b1;
        frames(2);
        chk("post_rst_invuln", invuln, 0);

        // three spaced hits end in DEAD
        do_hit(); frames(125);
        do_hit(); frames(125);
        do_hit();
        chk("death_damage", damage, 1);
        chk("death_heart", heart, 0);
        chk("death_dead", dead, 1);
        keycode = 8'h07;
        frames(5);
        chk("dead_nomove", userX, 34);
        keycode = 8'h00;
        frames(1);
        keycode = 8'h19; pulses = 0;
        for (int f = 0; f < 3; f++) begin
            @(negedge frame_clk);
            pulses += int'(bomb_drop);
        end
        keycode = 8'h00;
        chk("dead_nobomb", pulses, 0);
        do_hit();
        chk("dead_nohit", {29'd0, damage, heart}, 0);
        #2 Reset_n = 1'b0;
        #1;
        chk("dead_rst", {dead, heart}, 4'b0011);
        @(negedge frame_clk);
        Reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
